// File: rtl/shift_cmd_sequencer_if.sv
// Request, rotate-stage and result signals of shift_cmd_sequencer.
// master is the sequencer side; slave is the source, the rotate stage and the consumer.
interface shift_cmd_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_dir;
    logic [1:0] in_reps;
    logic [7:0] sh_a;
    logic [2:0] sh_amt;
    logic       sh_dir;
    logic [7:0] sh_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        input  in_valid, in_data, in_amt, in_dir, in_reps, sh_y, out_ready,
        output in_ready, sh_a, sh_amt, sh_dir, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, in_amt, in_dir, in_reps, sh_y, out_ready,
        input  in_ready, sh_a, sh_amt, sh_dir, out_valid, out_data
    );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Queues rotate requests and drives an external combinational rotate stage,
// re-circulating its result for multi-pass requests.
module shift_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    shift_cmd_sequencer_if.master       bus,
    output logic                        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROT  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Entry layout: {data[13:6], amt[5:3], dir[2], reps[1:0]}
    logic [13:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [13:0]   head_s;
    logic          push_s, pop_s;

    logic [1:0] state_q, state_d;
    logic [7:0] sh_a_q, sh_a_d;
    logic [2:0] sh_amt_q, sh_amt_d;
    logic       sh_dir_q, sh_dir_d;
    logic [1:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;

    assign bus.in_ready  = (count_q != CNT_FULL);
    assign push_s        = bus.in_valid & bus.in_ready;
    assign head_s        = mem_q[rd_ptr_q];
    assign bus.sh_a      = sh_a_q;
    assign bus.sh_amt    = sh_amt_q;
    assign bus.sh_dir    = sh_dir_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != S_IDLE) | (count_q != CNT_ZERO);

    // Request FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 14'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {bus.in_data, bus.in_amt, bus.in_dir, bus.in_reps};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer next-state: pop in IDLE, re-circulate in ROT, hold result in DONE
    always_comb begin
        state_d     = state_q;
        sh_a_d      = sh_a_q;
        sh_amt_d    = sh_amt_q;
        sh_dir_d    = sh_dir_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pop_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != CNT_ZERO) begin
                    pop_s    = 1'b1;
                    sh_a_d   = head_s[13:6];
                    sh_amt_d = head_s[5:3];
                    sh_dir_d = head_s[2];
                    cnt_d    = head_s[1:0];
                    state_d  = S_ROT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROT: begin
                if (cnt_q == 2'd0) begin
                    out_data_d  = bus.sh_y;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    sh_a_d = bus.sh_y;
                    cnt_d  = cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // Sequencer state and rotate-stage operand registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sh_a_q      <= 8'h00;
            sh_amt_q    <= 3'd0;
            sh_dir_q    <= 1'b0;
            cnt_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_amt_q    <= sh_amt_d;
            sh_dir_q    <= sh_dir_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed self-checking bench for shift_cmd_sequencer with a behavioural rotate stage.
module tb_shift_cmd_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    int   errs  = 0;
    int   total = 0;
    int   cyc   = 0;
    logic [7:0] exp_q [$];
    logic mon_en     = 1'b0;
    logic prev_valid = 1'b0;

    shift_cmd_sequencer_if bus ();

    shift_cmd_sequencer #(.DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rot(input logic [7:0] d, input logic [2:0] a, input logic r);
        logic [15:0] t;
        if (r) begin
            t = {d, d} >> a;
            return t[7:0];
        end else begin
            t = {d, d} << a;
            return t[15:8];
        end
    endfunction

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a,
                                         input logic r, input logic [1:0] reps);
        logic [7:0] v;
        v = d;
        for (int i = 0; i <= int'(reps); i++) v = rot(v, a, r);
        return v;
    endfunction

    assign bus.sh_y = rot(bus.sh_a, bus.sh_amt, bus.sh_dir);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ordering scoreboard: every rising out_valid must match the oldest queued request
    always @(negedge clk) begin
        if (mon_en && bus.out_valid && !prev_valid) begin
            if (exp_q.size() == 0) chk("mon_extra", 32'(exp_q.size()), 32'd1);
            else chk("mon_order", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        prev_valid <= bus.out_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [1:0] r);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dr;
        bus.in_reps  = r;
        while (!bus.in_ready && n < 100) begin
            step(1);
            n++;
        end
        chk("push_accept", 32'(n < 100), 32'd1);
        step(1);
        if (mon_en) exp_q.push_back(model(d, a, dr, r));
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] exp, output int t);
        bit found;
        found = 1'b0;
        t = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.out_valid) begin
                found = 1'b1;
                t = cyc;
                chk(tag, 32'(bus.out_data), 32'(exp));
            end
            step(1);
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        logic [7:0] bp_exp [5];
        logic [7:0] d;
        int acc, t0, t1, t2, stale;

        bp_exp = '{8'h22, 8'h44, 8'h66, 8'h88, 8'hAA};
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_amt    = 3'd0;
        bus.in_dir    = 1'b0;
        bus.in_reps   = 2'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'h00);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_sh_a",      32'(bus.sh_a),      32'h00);
        chk("rst_sh_amt",    32'(bus.sh_amt),    32'd0);
        step(1);
        reset_n = 1'b1;
        step(1);

        // Single pass: rotr1(0x81) = 0xC0
        bus.out_ready = 1'b1;
        push(8'h81, 3'd1, 1'b1, 2'd0);
        chk("single_e0_valid", 32'(bus.out_valid), 32'd0);
        chk("single_e0_busy",  32'(busy),          32'd1);
        step(1);
        chk("single_sh_a",   32'(bus.sh_a),      32'h81);
        chk("single_sh_amt", 32'(bus.sh_amt),    32'd1);
        chk("single_sh_dir", 32'(bus.sh_dir),    32'd1);
        chk("single_e1_valid", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data",  32'(bus.out_data),  32'hC0);
        step(1);
        chk("single_drop",  32'(bus.out_valid), 32'd0);
        chk("single_idle",  32'(busy),          32'd0);

        // Multi-pass: rotl3 x3 of 0x81, sh_a 0x81 -> 0x0C -> 0x60, result 0x03
        push(8'h81, 3'd3, 1'b0, 2'd2);
        step(1);
        chk("multi_sh_a0", 32'(bus.sh_a), 32'h81);
        step(1);
        chk("multi_sh_a1", 32'(bus.sh_a), 32'h0C);
        step(1);
        chk("multi_sh_a2", 32'(bus.sh_a), 32'h60);
        chk("multi_early", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("multi_valid", 32'(bus.out_valid), 32'd1);
        chk("multi_data",  32'(bus.out_data),  32'h03);
        step(2);

        // Backpressure: six back-to-back offers, five fit
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            d = 8'(8'h11 * (i + 1));
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_amt   = 3'd1;
            bus.in_dir   = 1'b0;
            bus.in_reps  = 2'd0;
            if (bus.in_ready) acc++;
            step(1);
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_full",     32'(bus.in_ready),  32'd0);
        chk("bp_valid",    32'(bus.out_valid), 32'd1);
        chk("bp_first",    32'(bus.out_data),  32'h22);
        step(3);
        chk("bp_frozen",   32'(bus.out_data),  32'h22);
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) wait_result("bp_order", bp_exp[i], t1);
        step(2);
        chk("bp_drained", 32'(busy), 32'd0);

        // Identity and ordering with reps+3 spacing
        push(8'h5A, 3'd0, 1'b0, 2'd3);
        t0 = cyc;
        push(8'hF0, 3'd4, 1'b1, 2'd0);
        wait_result("id_first",  8'h5A, t1);
        wait_result("id_second", 8'h0F, t2);
        chk("id_latency", 32'(t1 - t0), 32'd5);
        chk("id_spacing", 32'(t2 - t1), 32'd3);
        step(2);

        // Simultaneous push/pop at count DEPTH-1, eight requests through a depth-4 FIFO
        mon_en = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h13 * (i + 1)), 3'(i + 1), i[0], 2'(i));
        step(2);
        chk("pp_count3_ready", 32'(bus.in_ready),  32'd1);
        chk("pp_held_valid",   32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step(1);
        push(8'(8'h13 * 5), 3'd5, 1'b0, 2'd0);
        chk("pp_count_same", 32'(bus.in_ready), 32'd1);
        for (int i = 5; i < 8; i++) push(8'(8'h13 * (i + 1)), 3'(i + 1), i[0], 2'(i));
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) step(1);
        chk("pp_all_out", 32'(exp_q.size()), 32'd0);
        chk("pp_idle",    32'(busy),         32'd0);
        step(4);
        mon_en = 1'b0;

        // Reset mid-traffic
        bus.out_ready = 1'b0;
        push(8'hA5, 3'd1, 1'b0, 2'd0);
        push(8'h3C, 3'd2, 1'b1, 2'd1);
        step(3);
        chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_out_data",  32'(bus.out_data),  32'h00);
        chk("mid_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_busy",      32'(busy),          32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        step(2);
        bus.in_valid  = 1'b0;
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.out_valid) stale++;
        end
        chk("mid_no_stale", 32'(stale), 32'd0);
        chk("mid_post_busy", 32'(busy), 32'd0);
        chk("mid_post_ready", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end
endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Command sequencer that sits directly upstream of the 8-bit combinational rotate stage. It queues rotate requests from a valid/ready source and drives the rotate stage's operand, amount and direction from registers. It re-circulates the stage's result for multi-pass requests and presents the final word on a valid/ready output. The rotate stage is instantiated outside this block and connected through the `sh_*` ports, so that the stage stays reusable and purely combinational.

## Interface
- DEPTH, 4, request FIFO depth; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request FIFO not full; a request is accepted on an edge where in_valid & in_ready.
- in_data  in  8  operand.
- in_amt  in  3  rotate amount per pass, 0–7.
- in_dir  in  1  1 = rotate right, 0 = rotate left (stage convention).
- in_reps  in  2  extra passes; total passes = in_reps+1.
- sh_a  out  8  registered operand to rotate stage.
- sh_amt  out  3  registered amount to rotate stage.
- sh_dir  out  1  registered direction to rotate stage.
- sh_y  in  8  combinational result from rotate stage.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer on out_valid & out_ready.
- out_data  out  8  final result, registered.
- busy  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- FIFO: DEPTH entries of {data, amt, dir, reps}, 14 bits each. Pointers are log2(DEPTH) bits and wrap. The occupancy count is log2(DEPTH)+1 bits. in_ready = (count ≠ DEPTH). There is no write-through bypass; a pushed entry becomes poppable on the following edge.
- FSM states are IDLE, ROT and DONE. Reset state is IDLE.
- IDLE: if the FIFO is non-empty, pop the head. Load sh_a, sh_amt and sh_dir from the entry, load pass counter cnt ← reps, and go to ROT. If the FIFO is empty, stay in IDLE.
- ROT: if cnt = 0, then out_data ← sh_y, out_valid ← 1, and go to DONE. Otherwise sh_a ← sh_y, cnt ← cnt−1, and stay in ROT. sh_amt and sh_dir are held for the whole request.
- DONE: hold out_data and out_valid stable until out_ready. On the handshake edge, out_valid ← 0 and go to IDLE. The FIFO is not popped in DONE.
- Push and pop on the same edge are allowed: count is unchanged and both pointers advance.
- Results leave in request order. The net effect of a request is a rotate by (amt·(reps+1)) mod 8 in direction dir.

## Timing
- Reset (asynchronous, takes effect immediately) sets out_valid=0, out_data=0x00, sh_a=0x00, sh_amt=0, sh_dir=0, cnt=0, state=IDLE and FIFO empty. This gives in_ready=1 and busy=0. in_valid is ignored while reset_n=0.
- Latency with the block idle and the FIFO empty: request accepted at edge E0, popped at E1, out_valid high after edge E2+reps.
- Throughput: one result per reps+3 cycles when out_ready is held high.
- Backpressure: while in DONE with out_ready=0, pushes continue until the FIFO is full. Up to DEPTH+1 requests can be in flight.
- in_ready is combinational from count only; it does not depend on in_valid.
- Reset mid-operation discards the FIFO contents, the in-flight request and any pending output. out_valid falls asynchronously.

## Test plan
- Reset: assert reset_n=0 mid-traffic. Required: out_valid=0, out_data=0x00, in_ready=1, busy=0 immediately. After release, no stale result is emitted.
- Single request: data 0x81, amt 1, dir 1, reps 0, out_ready=1. Required: out_data=0xC0, out_valid high two edges after the accept edge, held exactly one cycle.
- Multi-pass: data 0x81, amt 3, dir 0, reps 2 (rotl 9 ≡ rotl 1). Required: out_data=0x03 four edges after accept, with sh_a stepping 0x81 → 0x0C → 0x60.
- Backpressure: out_ready=0, push 6 distinct requests back-to-back. Required: 5 accepted and in_ready low from then on, out_data frozen on the first result. Release out_ready and all 5 results appear in order.
- Identity and ordering: requests (0x5A, amt 0, reps 3), then (0xF0, amt 4, dir 1, reps 0), with out_ready=1. Required: 0x5A then 0x0F, in order, with each spacing matching reps+3.
- Simultaneous push/pop: with FIFO count=DEPTH−1, push on the same edge IDLE pops. Required: count unchanged, pointers wrap correctly, and no request is lost or duplicated across 2·DEPTH requests.
